// File: rtl/adder_256.sv
// adder_256: 256-bit unsigned pipelined adder with carry-out.
// The carry chain is cut into SLICE_W-bit slices, with one slice added per stage.
// Each stage register holds four things:
//   - the sum slices computed so far,
//   - the carry out of the newest slice,
//   - the operand slices not yet added, shifted down so the next slice sits at bit 0,
//   - a valid bit.
// ready_in is a global enable: when low, every register holds its value.
module adder_256 #(
  parameter int unsigned WIDTH   = 256,
  parameter int unsigned SLICE_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             valid_in,
  input  logic             ready_in,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ready_out
);

  localparam int unsigned STAGES = WIDTH / SLICE_W;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned SUM_W = (k + 1) * SLICE_W;
    localparam int unsigned REM_W = WIDTH - SUM_W;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic               carry_in;
    logic [SLICE_W:0]   slice_res;
    logic [SUM_W-1:0]   sum_d;
    logic [SUM_W-1:0]   sum_q;
    logic               carry_d;
    logic               carry_q;
    logic               valid_d;
    logic               valid_q;

    if (k == 0) begin : g_src
      // First slice comes straight from the ports; there is no carry-in.
      always_comb begin
        slice_a  = a[SLICE_W-1:0];
        slice_b  = b[SLICE_W-1:0];
        carry_in = 1'b0;
        valid_d  = valid_in;
        sum_d    = slice_res[SLICE_W-1:0];
      end
    end else begin : g_src
      // Later slices take the lowest pending operand slice and the carry from
      // the previous stage, and append the new sum slice above the lower ones.
      always_comb begin
        slice_a  = g_stage[k-1].g_ops.rem_a_q[SLICE_W-1:0];
        slice_b  = g_stage[k-1].g_ops.rem_b_q[SLICE_W-1:0];
        carry_in = g_stage[k-1].carry_q;
        valid_d  = g_stage[k-1].valid_q;
        sum_d    = {slice_res[SLICE_W-1:0], g_stage[k-1].sum_q};
      end
    end

    // One SLICE_W-bit add with carry; this is the only carry chain in the stage.
    always_comb begin
      slice_res = {1'b0, slice_a} + {1'b0, slice_b} + (SLICE_W + 1)'(carry_in);
      carry_d   = slice_res[SLICE_W];
    end

    // Stage register: synchronous reset; otherwise it loads only when downstream is ready.
    always_ff @(posedge clk) begin
      if (!reset) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (ready_in) begin
        valid_q <= valid_d;
        carry_q <= carry_d;
        sum_q   <= sum_d;
      end
    end

    if (REM_W > 0) begin : g_ops
      logic [REM_W-1:0] rem_a_d;
      logic [REM_W-1:0] rem_a_q;
      logic [REM_W-1:0] rem_b_d;
      logic [REM_W-1:0] rem_b_q;

      if (k == 0) begin : g_rem_src
        // Forward the upper operand slices that are still to be added.
        always_comb begin
          rem_a_d = a[WIDTH-1:SLICE_W];
          rem_b_d = b[WIDTH-1:SLICE_W];
        end
      end else begin : g_rem_src
        // Drop the slice consumed by this stage and shift the rest down.
        always_comb begin
          rem_a_d = g_stage[k-1].g_ops.rem_a_q[REM_W+SLICE_W-1:SLICE_W];
          rem_b_d = g_stage[k-1].g_ops.rem_b_q[REM_W+SLICE_W-1:SLICE_W];
        end
      end

      // Pending-operand register: same enable and reset as the rest of the stage.
      always_ff @(posedge clk) begin
        if (!reset) begin
          rem_a_q <= '0;
          rem_b_q <= '0;
        end else if (ready_in) begin
          rem_a_q <= rem_a_d;
          rem_b_q <= rem_b_d;
        end
      end
    end
  end

  // The last stage register is the output register.
  assign s         = g_stage[STAGES-1].sum_q;
  assign cout      = g_stage[STAGES-1].carry_q;
  assign ready_out = g_stage[STAGES-1].valid_q;

endmodule

// File: tb/tb_adder_256.sv
// tb_adder_256: randomized scoreboard bench for adder_256.
module tb_adder_256;

  localparam int unsigned W   = 256;
  localparam int unsigned LAT = 3;  // advancing edges after the accept edge

  logic         clk;
  logic         reset;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         valid_in;
  logic         ready_in;
  logic [W-1:0] s;
  logic         cout;
  logic         ready_out;

  adder_256 dut (
    .clk      (clk),
    .reset    (reset),
    .a        (a),
    .b        (b),
    .valid_in (valid_in),
    .ready_in (ready_in),
    .s        (s),
    .cout     (cout),
    .ready_out(ready_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W:0]  sum;
    int unsigned due;
  } exp_t;

  exp_t        q[$];
  int unsigned adv_count = 0;
  int          edge_kind = 3;  // 0 reset, 1 advance, 2 stall, 3 none yet
  int          n_cmp     = 0;
  int          n_err     = 0;
  logic [W+1:0] prev_out;

  task automatic chk(input string name, input logic [W+1:0] act, input logic [W+1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: each accepted op is due LAT advancing edges after its accept edge.
  always @(posedge clk) begin
    if (!reset) begin
      edge_kind = 0;
      q.delete();
    end else if (ready_in) begin
      edge_kind = 1;
      adv_count++;
      if (valid_in)
        q.push_back('{sum: (W+1)'(a) + (W+1)'(b), due: adv_count + LAT});
    end else begin
      edge_kind = 2;
    end
  end

  // Monitor: compare the DUT outputs mid-cycle against the model.
  always @(negedge clk) begin
    exp_t e;
    case (edge_kind)
      0: chk("reset_state", {ready_out, cout, s}, '0);
      1: begin
        if (q.size() > 0 && q[0].due == adv_count) begin
          e = q.pop_front();
          chk("ready_out_result", (W+2)'(ready_out), (W+2)'(1'b1));
          chk("sum", (W+2)'({cout, s}), (W+2)'(e.sum));
        end else begin
          chk("ready_out_bubble", (W+2)'(ready_out), '0);
        end
      end
      2: chk("stall_hold", {ready_out, cout, s}, prev_out);
      default: ;
    endcase
    prev_out = {ready_out, cout, s};
  end

  task automatic step(input logic [W-1:0] na, input logic [W-1:0] nb,
                      input logic nv, input logic nr, input logic nrst);
    @(posedge clk);
    #1;
    a = na; b = nb; valid_in = nv; ready_in = nr; reset = nrst;
  endtask

  function automatic logic [W-1:0] rnd256();
    logic [W-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  logic [W-1:0] ones;
  logic [W-1:0] ra;
  logic [W-1:0] rb;
  logic [W-1:0] one_w;

  initial begin
    ones  = '1;
    one_w = W'(1);
    a = '0; b = '0; valid_in = 1'b0; ready_in = 1'b1; reset = 1'b0;

    // Reset held for 10 cycles, then released with no valid input.
    for (int i = 0; i < 9; i++) step('0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step('0, '0, 1'b0, 1'b1, 1'b1);

    // Directed sums: basic, full carry ripple, slice 0 to 1 crossing, streaming pairs.
    step(W'(52'h1111111111111), (one_w << 168) - one_w, 1'b1, 1'b1, 1'b1);
    step(ones, one_w, 1'b1, 1'b1, 1'b1);
    step((one_w << 64) - one_w, one_w, 1'b1, 1'b1, 1'b1);
    step((one_w << 128) - one_w, one_w, 1'b1, 1'b1, 1'b1);
    step((one_w << 192) - one_w, (one_w << 192) - one_w, 1'b1, 1'b1, 1'b1);
    step(W'(108'h111111111111111111111111111), ones, 1'b1, 1'b1, 1'b1);
    step(W'(208'h0123456789abcdef0123456789abcdef0123456789abcdef0123),
         W'(220'hfedcba9876543210fedcba9876543210fedcba9876543210fedcba9), 1'b1, 1'b1, 1'b1);
    step(ones, ones, 1'b1, 1'b1, 1'b1);
    step('0, '0, 1'b1, 1'b1, 1'b1);

    // Four-cycle stall mid-stream; operands wiggle and must be ignored.
    for (int i = 0; i < 4; i++) step(rnd256(), rnd256(), 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(rnd256(), rnd256(), 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step('0, '0, 1'b0, 1'b1, 1'b1);

    // Reset with three ops in flight; none of them may emerge.
    for (int i = 0; i < 3; i++) step(rnd256(), rnd256(), 1'b1, 1'b1, 1'b1);
    step(rnd256(), rnd256(), 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step('0, '0, 1'b0, 1'b1, 1'b1);

    // Random traffic with random bubbles, stalls and carry-heavy operands.
    for (int i = 0; i < 1500; i++) begin
      ra = rnd256();
      case ($urandom_range(0, 4))
        0: rb = rnd256();
        1: rb = ~ra;
        2: rb = ~ra + one_w;
        3: begin ra = (one_w << (64 * $urandom_range(1, 3))) - one_w; rb = one_w; end
        default: begin ra = ones; rb = ones; end
      endcase
      step(ra, rb, $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, 1'b1);
    end

    // Drain the pipe, then confirm every expected result was seen.
    for (int i = 0; i < 8; i++) step('0, '0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("drain_empty", (W+2)'(q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
